// File: rtl/secuenciador_seleccion_byte.sv
// Purpose : counter-based sequencer that walks every byte position of every kernel line
//           and drives seleccion / linea / configuracion towards the kernel-line byte muxes.
// Latency : iniciar sampled at edge N -> valida high after edge N; one position per cycle.
// Backpress: a transfer is valida && avanzar; with avanzar low every output holds.
//
// Ports:
//   clk, reset     rising-edge clock, asynchronous active-high reset
//   iniciar        start pulse, only looked at in REPOSO
//   avanzar        consumer ready
//   seleccion      current byte position        (ANCHO_SEL bits)
//   linea          current kernel line          (ANCHO_LIN bits)
//   configuracion  thermometer code of seleccion (POSICIONES-1 bits)
//   valida         a position is presented (ACTIVO)
//   ocupado        high in ACTIVO and FIN
//   fin            one-cycle end-of-pass pulse
//
// Optional macro SELECCION_SERPENTINA_EN: odd lines walk positions downwards
// (POSICIONES-1 .. 0); when undefined every line ascends.
module secuenciador_seleccion_byte #(
   parameter int POSICIONES = 4,
   parameter int LINEAS     = 5,
   parameter int ANCHO_SEL  = $clog2(POSICIONES),
   parameter int ANCHO_LIN  = (LINEAS > 1) ? $clog2(LINEAS) : 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  iniciar,
   input  logic                  avanzar,
   output logic [ANCHO_SEL-1:0]  seleccion,
   output logic [ANCHO_LIN-1:0]  linea,
   output logic [POSICIONES-2:0] configuracion,
   output logic                  valida,
   output logic                  ocupado,
   output logic                  fin
);

   typedef enum logic [1:0] {
      REPOSO = 2'd0,
      ACTIVO = 2'd1,
      FIN    = 2'd2
   } estado_t;

   localparam logic [ANCHO_SEL-1:0] POS_MAX = ANCHO_SEL'(POSICIONES - 1);
   localparam logic [ANCHO_LIN-1:0] LIN_MAX = ANCHO_LIN'(LINEAS - 1);

   estado_t              estado, estado_sig;
   logic [ANCHO_SEL-1:0] pos_q, pos_sig;
   logic [ANCHO_LIN-1:0] lin_q, lin_sig;

   // Direction of the current line and of the line that follows it.
   logic descendente;
   logic descendente_sig;

`ifdef SELECCION_SERPENTINA_EN
   assign descendente     = lin_q[0];
   assign descendente_sig = ~lin_q[0];
`else
   assign descendente     = 1'b0;
   assign descendente_sig = 1'b0;
`endif

   // End-of-line / end-of-pass detection by explicit compare so non-power-of-two
   // parameters never rely on counter overflow.
   logic ultima_pos;
   logic ultima_lin;

   assign ultima_pos = descendente ? (pos_q == '0) : (pos_q == POS_MAX);
   assign ultima_lin = (lin_q == LIN_MAX);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         estado <= REPOSO;
         pos_q  <= '0;
         lin_q  <= '0;
      end else begin
         estado <= estado_sig;
         pos_q  <= pos_sig;
         lin_q  <= lin_sig;
      end
   end

   always_comb begin
      estado_sig = estado;
      pos_sig    = pos_q;
      lin_sig    = lin_q;
      case (estado)
         REPOSO: begin
            if (iniciar) begin
               // Line 0 is even, so it always starts at position 0.
               estado_sig = ACTIVO;
               pos_sig    = '0;
               lin_sig    = '0;
            end
         end
         ACTIVO: begin
            if (avanzar) begin
               if (ultima_pos) begin
                  if (ultima_lin) begin
                     estado_sig = FIN;
                     pos_sig    = '0;
                     lin_sig    = '0;
                  end else begin
                     lin_sig = lin_q + 1'b1;
                     pos_sig = descendente_sig ? POS_MAX : '0;
                  end
               end else begin
                  pos_sig = descendente ? (pos_q - 1'b1) : (pos_q + 1'b1);
               end
            end
         end
         FIN: begin
            estado_sig = REPOSO;
         end
         default: begin
            estado_sig = REPOSO;
            pos_sig    = '0;
            lin_sig    = '0;
         end
      endcase
   end

   // Outputs decode from the state register only, so an asynchronous reset
   // clears them without waiting for a clock edge.
   always_comb begin
      valida    = (estado == ACTIVO);
      ocupado   = (estado == ACTIVO) || (estado == FIN);
      fin       = (estado == FIN);
      seleccion = valida ? pos_q : '0;
      linea     = valida ? lin_q : '0;
   end

   // Thermometer code: bit k set iff seleccion > k.
   always_comb begin
      configuracion = '0;
      for (int k = 0; k < POSICIONES - 1; k++) begin
         configuracion[k] = (seleccion > ANCHO_SEL'(k));
      end
   end

endmodule

// File: tb/tb_secuenciador_seleccion_byte.sv
// Bench for secuenciador_seleccion_byte: a table of pass scenarios (ready pattern,
// stray start pulses, abort point) with expected transfer / fin counts, and a
// scoreboard queue of expected positions loaded at each start.
module tb_secuenciador_seleccion_byte;

   localparam int P = 4;
`ifdef SELECCION_SERPENTINA_EN
   localparam int L = 2;
   localparam bit SERP = 1'b1;
`else
   localparam int L = 5;
   localparam bit SERP = 1'b0;
`endif
   localparam int AS = $clog2(P);
   localparam int AL = (L > 1) ? $clog2(L) : 1;
   localparam int N  = P * L;

   logic          clk = 1'b0;
   logic          reset;
   logic          iniciar;
   logic          avanzar;
   logic [AS-1:0] seleccion;
   logic [AL-1:0] linea;
   logic [P-2:0]  configuracion;
   logic          valida;
   logic          ocupado;
   logic          fin;

   secuenciador_seleccion_byte #(
      .POSICIONES (P),
      .LINEAS     (L)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .iniciar       (iniciar),
      .avanzar       (avanzar),
      .seleccion     (seleccion),
      .linea         (linea),
      .configuracion (configuracion),
      .valida        (valida),
      .ocupado       (ocupado),
      .fin           (fin)
   );

   always #5 clk = ~clk;

   typedef struct {
      int sel;
      int lin;
      int cfg;
   } paso_t;

   typedef struct {
      bit aleatorio;  // avanzar toggled pseudo-randomly
      bit pulsos;     // stray iniciar pulses during ACTIVO and FIN
      int abortar;    // assert reset after this many transfers (0 = never)
      int exp_xfer;
      int exp_fin;
   } vector_t;

   paso_t   sb[$];
   vector_t tabla[6];

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int termo(input int s);
      int c = 0;
      for (int k = 0; k < P - 1; k++)
         if (s > k) c = c | (1 << k);
      return c;
   endfunction

   task automatic cargar_modelo();
      int s;
      sb.delete();
      for (int l = 0; l < L; l++) begin
         for (int p = 0; p < P; p++) begin
            s = (SERP && (l % 2 == 1)) ? (P - 1 - p) : p;
            sb.push_back('{s, l, termo(s)});
         end
      end
   endtask

   task automatic check_ceros(input string tag);
      check({tag, "_seleccion"},     32'(seleccion),     0);
      check({tag, "_linea"},         32'(linea),         0);
      check({tag, "_configuracion"}, 32'(configuracion), 0);
      check({tag, "_valida"},        32'(valida),        0);
      check({tag, "_ocupado"},       32'(ocupado),       0);
      check({tag, "_fin"},           32'(fin),           0);
   endtask

   task automatic run_pass(input vector_t v, output int nx, output int nf, output int nc);
      paso_t       e;
      bit          listo;
      bit          hay_prev;
      bit          pa;
      logic [31:0] ps, pl, pc;
      nx = 0; nf = 0; nc = 0;
      listo = 1'b0; hay_prev = 1'b0; pa = 1'b1;
      ps = 0; pl = 0; pc = 0;
      @(negedge clk);
      cargar_modelo();
      avanzar = 1'b0;
      iniciar = 1'b1;
      @(posedge clk);
      @(negedge clk);
      iniciar = 1'b0;
      check("latencia_valida", 32'(valida), 1);
      while (!listo && nc < 500) begin
         if (fin === 1'b1) begin
            nf++;
            check("fin_tras_ultima", sb.size(), 0);
            check("fin_valida", 32'(valida), 0);
            check("fin_ocupado", 32'(ocupado), 1);
            check("fin_seleccion", 32'(seleccion), 0);
            check("fin_configuracion", 32'(configuracion), 0);
            if (v.pulsos) iniciar = 1'b1;
            @(posedge clk);
            @(negedge clk);
            iniciar = 1'b0;
            check("fin_un_ciclo", 32'(fin), 0);
            check("ocupado_cae", 32'(ocupado), 0);
            check("reposo_valida", 32'(valida), 0);
            check("reposo_configuracion", 32'(configuracion), 0);
            listo = 1'b1;
         end else if (valida === 1'b1) begin
            if (hay_prev && !pa) begin
               check("espera_seleccion", 32'(seleccion), ps);
               check("espera_linea", 32'(linea), pl);
               check("espera_configuracion", 32'(configuracion), pc);
            end
            if (v.abortar != 0 && nx == v.abortar) begin
               reset = 1'b1;
               #1;
               check_ceros("aborto_async");
               @(posedge clk);
               @(negedge clk);
               reset = 1'b0;
               avanzar = 1'b0;
               iniciar = 1'b0;
               @(posedge clk);
               @(negedge clk);
               check("aborto_sin_fin", 32'(fin), 0);
               check("aborto_reposo", 32'(ocupado), 0);
               sb.delete();
               listo = 1'b1;
            end else begin
               pa = v.aleatorio ? ($urandom_range(0, 1) == 1) : 1'b1;
               avanzar = pa;
               if (v.pulsos) iniciar = (nc % 3 == 0);
               ps = 32'(seleccion);
               pl = 32'(linea);
               pc = 32'(configuracion);
               hay_prev = 1'b1;
               if (pa) begin
                  if (sb.size() == 0) begin
                     checks++;
                     errors++;
                     $display("FAIL transferencia_extra: got %0d transfers expected %0d", nx + 1, N);
                  end else begin
                     e = sb.pop_front();
                     check("seleccion", 32'(seleccion), e.sel);
                     check("linea", 32'(linea), e.lin);
                     check("configuracion", 32'(configuracion), e.cfg);
                  end
                  nx++;
               end
            end
         end else begin
            check("valida_inesperada", 32'(valida), 1);
            listo = 1'b1;
         end
         if (!listo) begin
            @(posedge clk);
            @(negedge clk);
            nc++;
         end
      end
      if (!listo) begin
         checks++;
         errors++;
         $display("FAIL timeout_pasada: got %0d cycles expected fin before 500", nc);
      end
      avanzar = 1'b0;
      iniciar = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got simulation time limit expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int nx, nf, nc;
      tabla[0] = '{1'b0, 1'b0, 0, N, 1};
      tabla[1] = '{1'b1, 1'b0, 0, N, 1};
      tabla[2] = '{1'b0, 1'b1, 0, N, 1};
      tabla[3] = '{1'b0, 1'b0, 7, 7, 0};
      tabla[4] = '{1'b1, 1'b1, 0, N, 1};
      tabla[5] = '{1'b0, 1'b0, 0, N, 1};

      reset   = 1'b1;
      iniciar = 1'b0;
      avanzar = 1'b0;
      repeat (2) @(negedge clk);
      check_ceros("reset");
      reset = 1'b0;
      @(negedge clk);
      check_ceros("reposo");

      for (int i = 0; i < 6; i++) begin
         run_pass(tabla[i], nx, nf, nc);
         check($sformatf("vec%0d_transferencias", i), nx, tabla[i].exp_xfer);
         check($sformatf("vec%0d_fin", i), nf, tabla[i].exp_fin);
         if (tabla[i].abortar == 0)
            check($sformatf("vec%0d_cola_vacia", i), sb.size(), 0);
         if (!tabla[i].aleatorio && tabla[i].abortar == 0)
            check($sformatf("vec%0d_ciclos", i), nc, N);
         repeat (2) @(negedge clk);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
